// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - 1 ms timebase with round-robin periodic tick channels
// Ports:
//   clk_100mhz : single clock, all logic on its rising edge
//   rst        : asynchronous active-high reset
//   cfg_we     : channel config write request, held until accepted
//   cfg_ch     : channel to configure
//   cfg_period : period in ms (0 = channel never ticks)
//   cfg_en     : channel enable
//   cfg_ready  : write accepted in any cycle with cfg_we && cfg_ready
//   ms_tick    : registered one-cycle 1 ms strobe
//   tick       : registered one-cycle per-channel pulses
//   pause      : only with TICK_SCHED_PAUSE_EN; freezes the prescaler
// Optional feature macro: TICK_SCHED_PAUSE_EN
module tick_scheduler #(
   parameter int NCH      = 4,
   parameter int CW       = 2,
   parameter int PW       = 16,
   parameter int PRESCALE = 100000
) (
   input  logic           clk_100mhz,
   input  logic           rst,
   input  logic           cfg_we,
   input  logic [CW-1:0]  cfg_ch,
   input  logic [PW-1:0]  cfg_period,
   input  logic           cfg_en,
   output logic           cfg_ready,
   output logic           ms_tick,
   output logic [NCH-1:0] tick
`ifdef TICK_SCHED_PAUSE_EN
   ,
   input  logic           pause
`endif
);

   localparam logic [31:0]   CNT_MAX  = 32'(PRESCALE - 1);
   localparam logic [CW-1:0] IDX_LAST = CW'(NCH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  idx_q, idx_d;
   logic [31:0]    cnt_q, cnt_d;
   logic           ms_tick_q, ms_tick_d;
   logic [NCH-1:0] tick_q, tick_d;
   logic [PW-1:0]  period_q [NCH];
   logic [PW-1:0]  period_d [NCH];
   logic [PW-1:0]  remain_q [NCH];
   logic [PW-1:0]  remain_d [NCH];
   logic [NCH-1:0] en_q, en_d;
   logic           cnt_run;

`ifdef TICK_SCHED_PAUSE_EN
   assign cnt_run = !pause;
`else
   assign cnt_run = 1'b1;
`endif

   // Prescaler free-runs independently of the sweep and config traffic.
   always_comb begin
      cnt_d     = cnt_q;
      ms_tick_d = 1'b0;
      if (cnt_run) begin
         cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + 32'd1;
         ms_tick_d = (cnt_q == CNT_MAX);
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      tick_d    = '0;
      period_d  = period_q;
      remain_d  = remain_q;
      en_d      = en_q;
      // Config is locked out for the strobe cycle and the whole sweep, so a
      // write never races the shared decrement datapath.
      cfg_ready = (state_q == IDLE) && !ms_tick_q;

      case (state_q)
         IDLE: begin
            if (ms_tick_q) begin
               state_d = SWEEP;
               idx_d   = '0;
            end
         end
         SWEEP: begin
            if (en_q[idx_q] && (period_q[idx_q] != '0)) begin
               // remain <= 1 also covers a stale 0, so the channel reloads
               // instead of wrapping.
               if (remain_q[idx_q] <= PW'(1)) begin
                  tick_d[idx_q]   = 1'b1;
                  remain_d[idx_q] = period_q[idx_q];
               end else begin
                  remain_d[idx_q] = remain_q[idx_q] - PW'(1);
               end
            end
            if (idx_q == IDX_LAST) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase

      if (cfg_we && cfg_ready) begin
         period_d[cfg_ch] = cfg_period;
         remain_d[cfg_ch] = cfg_period;
         en_d[cfg_ch]     = cfg_en;
      end
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         ms_tick_q <= 1'b0;
         tick_q    <= '0;
         en_q      <= '0;
         for (int k = 0; k < NCH; k++) begin
            period_q[k] <= '0;
            remain_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         ms_tick_q <= ms_tick_d;
         tick_q    <= tick_d;
         en_q      <= en_d;
         for (int k = 0; k < NCH; k++) begin
            period_q[k] <= period_d[k];
            remain_q[k] <= remain_d[k];
         end
      end
   end

   assign ms_tick = ms_tick_q;
   assign tick    = tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized self-checking bench for tick_scheduler
module tb_tick_scheduler;

   localparam int NCH      = 4;
   localparam int CW       = 2;
   localparam int PW       = 16;
   localparam int PRESCALE = 10;
   localparam int RING     = 16;

   logic           clk_100mhz = 1'b0;
   logic           rst        = 1'b1;
   logic           cfg_we     = 1'b0;
   logic [CW-1:0]  cfg_ch     = '0;
   logic [PW-1:0]  cfg_period = '0;
   logic           cfg_en     = 1'b0;
   logic           cfg_ready;
   logic           ms_tick;
   logic [NCH-1:0] tick;

   int checks   = 0;
   int failures = 0;

   always #5 clk_100mhz = ~clk_100mhz;

   tick_scheduler #(
      .NCH(NCH), .CW(CW), .PW(PW), .PRESCALE(PRESCALE)
   ) dut (
      .clk_100mhz(clk_100mhz),
      .rst(rst),
      .cfg_we(cfg_we),
      .cfg_ch(cfg_ch),
      .cfg_period(cfg_period),
      .cfg_en(cfg_en),
      .cfg_ready(cfg_ready),
      .ms_tick(ms_tick),
      .tick(tick)
   );

   // Reference model: cycle number since reset release, plus per-channel
   // count of strobes seen since the last write. Channel k ticks two-plus-k
   // cycles after every strobe on which its strobe count is a multiple of
   // its period.
   int             cyc = 0;
   int             m_period [NCH];
   bit             m_en     [NCH];
   int             m_seen   [NCH];
   bit [NCH-1:0]   ring     [RING];
   bit             cmp_on = 1'b0;

   function automatic bit exp_ms(int c);
      return (c > 0) && (c % PRESCALE == 0);
   endfunction

   function automatic bit exp_ready(int c);
      return !((c >= PRESCALE) && (c % PRESCALE <= NCH));
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int k = 0; k < NCH; k++) begin
         m_period[k] = 0;
         m_en[k]     = 1'b0;
         m_seen[k]   = 0;
      end
      for (int i = 0; i < RING; i++) ring[i] = '0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   initial begin : model
      model_reset();
      forever begin
         @(posedge clk_100mhz or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            if (cfg_we && exp_ready(cyc)) begin
               m_period[cfg_ch] = int'(cfg_period);
               m_en[cfg_ch]     = cfg_en;
               m_seen[cfg_ch]   = 0;
            end
            if (exp_ms(cyc)) begin
               for (int k = 0; k < NCH; k++) begin
                  if (m_en[k] && m_period[k] != 0) begin
                     m_seen[k]++;
                     if (m_seen[k] % m_period[k] == 0)
                        ring[(cyc + 2 + k) % RING][k] = 1'b1;
                  end
               end
            end
            ring[cyc % RING] = '0;
            cyc++;
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk_100mhz);
         if (cmp_on) begin
            chk("ms_tick", 32'(ms_tick), 32'(exp_ms(cyc)));
            chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready(cyc)));
            chk("tick", 32'(tick), 32'(ring[cyc % RING]));
         end
      end
   end

   task automatic wait_cyc(input int n);
      int b;
      b = 0;
      while (cyc < n && b < 2000) begin
         @(negedge clk_100mhz);
         b++;
      end
      chk("wait_cyc", 32'(cyc), 32'(n));
   endtask

   // Called at a negedge; holds the request until the handshake completes.
   task automatic do_write(input int ch, input int p, input bit en);
      int b;
      b          = 0;
      cfg_ch     = CW'(ch);
      cfg_period = PW'(p);
      cfg_en     = en;
      cfg_we     = 1'b1;
      while (!cfg_ready && b < 20) begin
         @(negedge clk_100mhz);
         b++;
      end
      chk("cfg_accept", 32'(cfg_ready), 32'd1);
      @(negedge clk_100mhz);
      cfg_we = 1'b0;
   endtask

   task automatic count_ticks_until(input int n, output int pulses);
      int b;
      pulses = 0;
      b      = 0;
      while (cyc < n && b < 2000) begin
         @(negedge clk_100mhz);
         if (tick != '0) pulses++;
         b++;
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int pulses;
      int r;
      int per;
      rst = 1'b1;
      repeat (3) @(negedge clk_100mhz);
      rst    = 1'b0;
      cmp_on = 1'b1;
      @(negedge clk_100mhz);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_ms_tick", 32'(ms_tick), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

      wait_cyc(10);
      chk("strobe10", 32'(ms_tick), 32'd1);
      wait_cyc(11);
      chk("strobe11", 32'(ms_tick), 32'd0);
      wait_cyc(20);
      chk("strobe20", 32'(ms_tick), 32'd1);
      wait_cyc(30);
      chk("strobe30", 32'(ms_tick), 32'd1);
      count_ticks_until(100, pulses);
      chk("idle_ticks", 32'(pulses), 32'd0);

      wait_cyc(106);
      do_write(1, 3, 1'b1);
      wait_cyc(113);
      chk("ch1_p3_113", 32'(tick), 32'd0);
      wait_cyc(123);
      chk("ch1_p3_123", 32'(tick), 32'd0);
      wait_cyc(133);
      chk("ch1_p3_133", 32'(tick), 32'b0010);

      wait_cyc(136);
      do_write(0, 1, 1'b1);
      do_write(3, 2, 1'b1);
      wait_cyc(142);
      chk("ch0_p1_142", 32'(tick), 32'b0001);
      wait_cyc(155);
      chk("ch3_p2_155", 32'(tick), 32'b1000);

      wait_cyc(170);
      chk("coll_strobe", 32'(ms_tick), 32'd1);
      cfg_ch     = 2'd2;
      cfg_period = 16'd1;
      cfg_en     = 1'b1;
      cfg_we     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk_100mhz);
         chk("coll_busy", 32'(cfg_ready), 32'd0);
      end
      @(negedge clk_100mhz);
      chk("coll_accept_cyc", 32'(cyc), 32'd175);
      chk("coll_accept", 32'(cfg_ready), 32'd1);
      @(negedge clk_100mhz);
      cfg_we = 1'b0;
      wait_cyc(184);
      chk("ch2_p1_184", 32'(tick), 32'b0100);

      wait_cyc(186);
      do_write(2, 0, 1'b1);
      wait_cyc(194);
      chk("ch2_p0_194", 32'(tick[2]), 32'd0);
      wait_cyc(196);
      do_write(1, 2, 1'b1);
      wait_cyc(203);
      chk("ch1_rewrite_203", 32'(tick[1]), 32'd0);
      wait_cyc(213);
      chk("ch1_rewrite_213", 32'(tick[1]), 32'd1);

      wait_cyc(232);
      @(posedge clk_100mhz);
      #1;
      rst = 1'b1;
      @(negedge clk_100mhz);
      chk("midsweep_rst_tick", 32'(tick), 32'd0);
      @(negedge clk_100mhz);
      rst = 1'b0;
      count_ticks_until(60, pulses);
      chk("post_rst_ticks", 32'(pulses), 32'd0);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 25);
         repeat (r) @(negedge clk_100mhz);
         per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                           : int'($urandom_range(0, 6));
         do_write(int'($urandom_range(0, NCH - 1)), per, ($urandom_range(0, 3) != 0));
      end

      repeat (30) @(negedge clk_100mhz);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared millisecond timebase and periodic-event scheduler for the game logic. It divides `clk_100mhz` down to a one-cycle 1 ms strobe. One shared decrement datapath then serves NCH independently programmed timer channels in a round-robin sweep after each strobe. Each channel emits a one-cycle `tick` pulse every `period` ms; movement, firing cooldown and animation logic consume these pulses as enables instead of using derived clocks.

## Interface
- `NCH`, 4 — number of timer channels (power of 2, ≥2)
- `CW`, 2 — channel index width, = log2(NCH)
- `PW`, 16 — period width in ms
- `PRESCALE`, 100000 — `clk_100mhz` cycles per ms; must be ≥ NCH+2
- `clk_100mhz` in 1 — the single clock; all logic on its rising edge
- `rst` in 1 — asynchronous, active-high reset
- `cfg_we` in 1 — configuration write request, held until accepted
- `cfg_ch` in CW — channel to configure
- `cfg_period` in PW — period in ms; 0 means the channel never ticks
- `cfg_en` in 1 — channel enable
- `cfg_ready` out 1 — write is accepted in any cycle where `cfg_we && cfg_ready`
- `ms_tick` out 1 — registered 1 ms strobe, one cycle wide
- `tick` out NCH — registered per-channel pulses, one cycle wide
- `pause` in 1 — present only with `TICK_SCHED_PAUSE_EN` (see Configuration)

## Operation
- Prescaler: 32-bit `cnt` runs from 0 to PRESCALE-1 and wraps to 0. `ms_tick <= (cnt == PRESCALE-1)`.
- Per-channel state: `period[k]` (PW), `remain[k]` (PW), `en[k]`.
- FSM states: IDLE and SWEEP; `idx` is CW bits.
  - IDLE: if `ms_tick`, go to SWEEP with `idx=0`.
  - SWEEP: process channel `idx` each cycle. If `idx==NCH-1`, go to IDLE; otherwise `idx+1`.
- Processing channel k:
  - If `en[k]` and `period[k]!=0`:
    - if `remain[k]<=1`: set `tick[k]<=1` and reload `remain[k]<=period[k]`;
    - otherwise `remain[k]<=remain[k]-1`.
  - Otherwise the channel is unchanged and does not tick.
- `tick` is cleared every cycle unless set by processing, so each pulse lasts exactly one cycle.
- `cfg_ready = (state==IDLE) && !ms_tick` (combinational).
- Accepted write: `period[cfg_ch]<=cfg_period`, `remain[cfg_ch]<=cfg_period`, `en[cfg_ch]<=cfg_en`. This restarts the channel's count; no tick is emitted for the write itself.
- A period of 1 ticks every ms. A period of P ticks on every P-th `ms_tick` after the write.
- The prescaler never stalls for the FSM or for config writes.

## Timing
- Reset values: `cnt=0`, `ms_tick=0`, `tick=0`, state IDLE, `idx=0`, and all `period`, `remain`, `en` = 0. `cfg_ready=1` as soon as reset is released.
- First `ms_tick` is high in cycle PRESCALE after reset release (counting the first edge as cycle 1). It repeats every PRESCALE cycles.
- If `ms_tick` is high in cycle T, a due `tick[k]` is high in cycle T+2+k.
- `cfg_ready` is low from cycle T through T+NCH, i.e. NCH+1 cycles per ms.
- A write pending during that window is accepted in cycle T+NCH+1. It takes effect at the next sweep.
- Write arriving in the same cycle as `ms_tick`: not accepted that cycle; retried per the handshake.
- Since PRESCALE ≥ NCH+2, a sweep always completes before the next `ms_tick`. There is no overlap case.
- Reset asserted mid-sweep: everything returns to reset values immediately, including any in-flight `tick`.

## Configuration
- `TICK_SCHED_PAUSE_EN` defined:
  - adds input `pause`;
  - while `pause=1`, `cnt` holds its value and `ms_tick` stays 0;
  - a sweep already in progress completes normally;
  - config writes remain accepted while paused;
  - on release, counting resumes from the held `cnt` value.
- Not defined: no `pause` port exists, and the prescaler free-runs.

## Test plan
(All scenarios use PRESCALE=10, NCH=4.)
- Reset behaviour: hold `rst` for 3 cycles, then release → `tick=0`, `ms_tick=0`, `cfg_ready=1`. With no writes, `tick` stays 0 for 100 cycles.
- Strobe timing: run freely → `ms_tick` high in cycles 10, 20, 30, each exactly 1 cycle wide.
- Periodic channel: write ch1, period=3, en=1 while idle → `tick[1]` high exactly in cycle T+3 of every 3rd `ms_tick` (T). No other `tick` bits pulse.
- Two channels: ch0 period=1 and ch3 period=2 → `tick[0]` at T+2 of every ms; `tick[3]` at T+5 of every 2nd ms.
- Handshake under collision: raise `cfg_we` in a `ms_tick` cycle T → `cfg_ready` is 0 for T..T+4, the write is accepted at T+5, and the new period applies from the next ms.
- Edge cases:
  - period=0 with en=1 → never ticks;
  - rewriting ch1 mid-count restarts the count from the new period;
  - asserting `rst` at T+3 → `tick` is 0 from T+3 and all channels are disabled.
